rv32_lsu: RTL and testbench
===========================

// Module: rv32_lsu
// PURPOSE
//  RV32I load/store unit between the execute stage and the data-memory port.
//  Takes an address from the ALU and a funct3 from the L/S decoder. Checks alignment.
//  Drives a req/gnt/rvalid memory handshake with byte enables and lane-replicated store data.
//  Returns sign- or zero-extended load data, or an error code, to writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  16  cycles allowed in REQ or WAIT before a bus-timeout error; 0 disables the timeout
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  rst_n          in   1   synchronous active-low reset
//  req_valid      in   1   execute stage presents a load/store
//  req_ready      out  1   LSU can accept a request (IDLE only)
//  req_is_store   in   1   1=store, 0=load
//  req_funct3     in   3   instr[14:12]
//  req_addr       in   32  effective byte address
//  req_wdata      in   32  rs2 value (stores)
//  mem_req        out  1   memory request, held until mem_gnt
//  mem_we         out  1   write enable
//  mem_be         out  4   byte enables
//  mem_addr       out  32  word address: {addr[31:2],2'b00}
//  mem_wdata      out  32  lane-replicated store data
//  mem_gnt        in   1   memory accepts the current request
//  mem_rvalid     in   1   load data valid
//  mem_rdata      in   32  load data word
//  rsp_valid      out  1   1-cycle completion pulse
//  rsp_data       out  32  extended load result (0 for stores and errors)
//  rsp_err        out  2   00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3
// BEHAVIOUR
//  Encodings:
//   - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
//   - Stores: SB=000, SH=001, SW=010.
//   - Any other funct3 is illegal.
//  Reset (rst_n=0 at a clk edge):
//   - State goes to IDLE; timeout counter clears.
//   - All outputs are 0, except req_ready=1.
//   - An in-flight transaction is abandoned with no rsp_valid.
//   - mem_gnt and mem_rvalid arriving later while in IDLE are ignored.
//  FSM states: IDLE, REQ, WAIT, RESP.
//   - IDLE: req_ready=1. When req_valid=1, latch all req_* inputs, then:
//       illegal funct3 -> RESP with err 11;
//       LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0 -> RESP with err 01;
//       otherwise -> REQ.
//     Illegal funct3 takes priority over misalignment.
//   - REQ: mem_req=1. mem_we, mem_be, mem_addr and mem_wdata stay stable until mem_gnt=1.
//     On gnt: a store goes to RESP with err 00; a load goes to WAIT.
//   - WAIT: sample mem_rvalid only in this state. On rvalid, extract and extend, then go to RESP.
//   - RESP: rsp_valid=1 for exactly 1 cycle, then IDLE. There is no back-pressure on rsp.
//  req_ready is 0 in REQ, WAIT and RESP. Requests arriving then are not accepted.
//  Byte enables:
//   - byte: 0001<<addr[1:0]
//   - half: 0011<<addr[1:0]
//   - word: 1111
//  Store data lane replication:
//   - SB: {4{b}}
//   - SH: {2{h}}
//   - SW: the word unchanged
//  Load extraction:
//   - Byte: rdata[8*addr[1:0] +: 8].
//   - Half: rdata[16*addr[1] +: 16].
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//  Timeout:
//   - Counter resets on entry to REQ and on entry to WAIT.
//   - If it reaches TIMEOUT_CYCLES without gnt (in REQ) or rvalid (in WAIT): go to RESP with err 10, and drop mem_req.
//   - gnt or rvalid arriving in the same cycle the counter expires wins: normal completion.
//  Latency from the accept edge to rsp_valid:
//   - Error responses: 1 cycle.
//   - Store with immediate gnt: 2 cycles.
//   - Load with immediate gnt and rvalid 1 cycle later: 3 cycles.
//  rsp_data is registered and valid only while rsp_valid=1. It reads 0 otherwise.
// TESTING
//  1. LB addr=0x103, rdata=0x80AABBCC -> mem_addr=0x100, be=1000, rsp_data=0xFFFFFF80, err=00.
//  2. SH addr=0x202, wdata=0x1234ABCD, gnt on the 1st REQ cycle -> be=1100, mem_wdata=0xABCDABCD, rsp_valid 2 cycles after accept.
//  3. LW addr=0x101 -> no mem_req; rsp_valid 1 cycle later with err=01. funct3=011 load -> err=11.
//  4. LHU addr=0x2, mem_gnt held 0 for 16 cycles -> mem_req drops, err=10; gnt on the 16th cycle -> normal completion.
//  5. Load in WAIT, rst_n=0 for 1 cycle, then rvalid -> no rsp_valid; req_ready=1; next request served correctly.
//  6. Back-to-back: req_valid held high through a load -> second request accepted only in IDLE after RESP, with no overlap.

Source files
------------

// File: rtl/rv32_lsu.sv
// rv32_lsu: RV32I load/store unit with alignment checks, req/gnt/rvalid memory handshake and bus timeout
// Ports: clk/rst_n (sync active-low); req_* from execute (req_ready only in IDLE);
// mem_* data-memory handshake (mem_addr word aligned, mem_wdata lane-replicated);
// rsp_valid/rsp_data/rsp_err one-cycle completion to writeback (err 00 ok, 01 misaligned, 10 timeout, 11 illegal).
module rv32_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, nxt;
  logic        is_store;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, cnt, sh, ext, ndata;
  logic [1:0]  nerr;
  logic        ill, mis, tmo;
  assign ill = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) || (req_is_store && req_funct3[2]);
  assign mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  // expiry is flagged in the last allowed cycle so gnt/rvalid in that same cycle still wins
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 1);
  assign sh  = mem_rdata >> {addr[1:0], 3'b000};
  assign ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
               f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : mem_rdata;
  assign req_ready = state == IDLE;
  assign mem_req   = state == REQ;
  assign mem_we    = mem_req && is_store;
  assign mem_addr  = mem_req ? {addr[31:2], 2'b00} : 32'h0;
  assign mem_be    = !mem_req ? 4'b0000 :
                     f3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                     f3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign mem_wdata = !mem_we ? 32'h0 :
                     f3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                     f3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
  assign rsp_valid = state == RESP;
  always_comb begin
    nxt   = state;
    nerr  = 2'b00;
    ndata = 32'h0;
    case (state)
      IDLE: if (req_valid) begin
        nxt  = (ill || mis) ? RESP : REQ;
        nerr = ill ? 2'b11 : mis ? 2'b01 : 2'b00;
      end
      REQ: if (mem_gnt) nxt = is_store ? RESP : WAIT;
        else if (tmo) begin
          nxt  = RESP;
          nerr = 2'b10;
        end
      WAIT: if (mem_rvalid) begin
        nxt   = RESP;
        ndata = ext;
      end else if (tmo) begin
        nxt  = RESP;
        nerr = 2'b10;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 32'h0;
      is_store <= 1'b0;
      f3       <= 3'b000;
      addr     <= 32'h0;
      wdata    <= 32'h0;
      rsp_data <= 32'h0;
      rsp_err  <= 2'b00;
    end else begin
      state    <= nxt;
      cnt      <= (state != nxt) ? 32'h0 : cnt + 32'd1;
      rsp_data <= ndata;
      rsp_err  <= nerr;
      if (state == IDLE && req_valid) begin
        is_store <= req_is_store;
        f3       <= req_funct3;
        addr     <= req_addr;
        wdata    <= req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_rv32_lsu.sv
// tb_rv32_lsu: directed self-checking bench for rv32_lsu
module tb_rv32_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  int checks = 0, errors = 0;
  int n;
  rv32_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step();
    req_valid = 1'b0;
  endtask
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, " req"}, {31'h0, mem_req}, 32'h1);
    chk({tag, " we"}, {31'h0, mem_we}, 32'h0);
    chk({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, " be"}, {28'h0, mem_be}, {28'h0, be});
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk({tag, " wait"}, {30'h0, mem_req, rsp_valid}, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = rd; step(); mem_rvalid = 1'b0;
    chk({tag, " rsp"}, {30'h0, rsp_valid, req_ready}, 32'h2);
    chk({tag, " data"}, rsp_data, exp);
    chk({tag, " err"}, {30'h0, rsp_err}, 32'h0);
    step();
    chk({tag, " idle"}, {rsp_data[29:0], rsp_valid, req_ready}, 32'h1);
  endtask
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
    issue(1'b1, f3, a, wd);
    chk({tag, " req"}, {30'h0, mem_req, mem_we}, 32'h3);
    chk({tag, " addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, " be"}, {28'h0, mem_be}, {28'h0, be});
    chk({tag, " wdata"}, mem_wdata, exp);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk({tag, " rsp"}, {29'h0, rsp_valid, rsp_err}, 32'h4);
    chk({tag, " data"}, rsp_data, 32'h0);
    step();
    chk({tag, " idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask
  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] err);
    issue(st, f3, a, 32'hFFFF_FFFF);
    chk({tag, " noreq"}, {31'h0, mem_req}, 32'h0);
    chk({tag, " rsp"}, {29'h0, rsp_valid, rsp_err}, {29'h0, 1'b1, err});
    chk({tag, " data"}, rsp_data, 32'h0);
    step();
    chk({tag, " idle"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask
  initial begin
    step(); step();
    chk("reset ready", {31'h0, req_ready}, 32'h1);
    chk("reset outs", {mem_req, mem_we, mem_be, rsp_valid, rsp_err}, 32'h0);
    chk("reset data", rsp_data | mem_addr | mem_wdata, 32'h0);
    rst_n = 1'b1;
    step();
    do_load("lb", 3'b000, 32'h103, 32'h80AA_BBCC, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h101, 32'h0000_F500, 4'b0010, 32'h0000_00F5);
    do_load("lh", 3'b001, 32'h002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    do_load("lhu0", 3'b101, 32'h000, 32'h1234_9ABC, 4'b0011, 32'h0000_9ABC);
    do_load("lw", 3'b010, 32'h7FC, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_store("sh", 3'b001, 32'h202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", 3'b000, 32'h301, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
    do_store("sw", 3'b010, 32'h404, 32'h0102_0304, 4'b1111, 32'h0102_0304);
    do_err("lw mis", 1'b0, 3'b010, 32'h101, 2'b01);
    do_err("lh mis", 1'b0, 3'b001, 32'h003, 2'b01);
    do_err("sw mis", 1'b1, 3'b010, 32'h002, 2'b01);
    do_err("ld 011", 1'b0, 3'b011, 32'h101, 2'b11);
    do_err("sb 100", 1'b1, 3'b100, 32'h000, 2'b11);
    // REQ timeout: mem_req held for exactly 16 cycles, then err 10
    issue(1'b0, 3'b101, 32'h2, 32'h0);
    n = 0;
    while (mem_req && n < 40) begin n++; step(); end
    chk("tmo req cycles", n, 16);
    chk("tmo req rsp", {29'h0, rsp_valid, rsp_err}, 32'h6);
    step();
    // gnt in the 16th REQ cycle wins over the timeout
    issue(1'b0, 3'b101, 32'h2, 32'h0);
    repeat (15) step();
    chk("late gnt req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("late gnt wait", {30'h0, mem_req, rsp_valid}, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000; step(); mem_rvalid = 1'b0;
    chk("late gnt rsp", {29'h0, rsp_valid, rsp_err}, 32'h4);
    chk("late gnt data", rsp_data, 32'h0000_BEEF);
    step();
    // WAIT timeout
    issue(1'b0, 3'b010, 32'h8, 32'h0);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin n++; step(); end
    chk("tmo wait cycles", n, 16);
    chk("tmo wait rsp", {29'h0, rsp_valid, rsp_err}, 32'h6);
    step();
    // reset while waiting for rvalid abandons the load
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("rst ready", {30'h0, rsp_valid, req_ready}, 32'h1);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555; step(); mem_rvalid = 1'b0;
    chk("rst rvalid ignored", {30'h0, rsp_valid, req_ready}, 32'h1);
    step();
    chk("rst ignored still", {30'h0, rsp_valid, req_ready}, 32'h1);
    do_load("post rst", 3'b000, 32'h0, 32'h0000_007F, 4'b0001, 32'h0000_007F);
    // back-to-back: req_valid held high throughout
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
    step();
    chk("b2b req", {30'h0, mem_req, req_ready}, 32'h2);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("b2b wait", {29'h0, mem_req, rsp_valid, req_ready}, 32'h0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344; step(); mem_rvalid = 1'b0;
    chk("b2b rsp", {30'h0, rsp_valid, req_ready}, 32'h2);
    chk("b2b data", rsp_data, 32'h1122_3344);
    req_is_store = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
    step();
    chk("b2b idle", {29'h0, mem_req, rsp_valid, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    chk("b2b 2nd req", {29'h0, mem_req, mem_we, req_ready}, 32'h6);
    chk("b2b 2nd addr", mem_addr, 32'h40);
    chk("b2b 2nd wdata", mem_wdata, 32'hCAFE_F00D);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    chk("b2b 2nd rsp", {29'h0, rsp_valid, rsp_err}, 32'h4);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
